// File: rtl/z16_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between fetch and data requesters.
// One command per grant, fixed MEM_LAT wait, one-cycle ack in RESP; requests wait while busy.
module z16_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              own_d_q, own_d_d;    // 1 = data requester owns the transaction
  logic              last_d_q, last_d_d;  // 1 = data requester was granted last
  logic              wen_q, wen_d;        // store command, already qualified by owner
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      own_d_q    <= 1'b0;
      last_d_q   <= 1'b1;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_d_q    <= own_d_d;
      last_d_q   <= last_d_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d_d    = own_d_q;
    last_d_d   = last_d_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_d    = i_d_req && (!i_if_req || !last_d_q);
    case (state_q)
      S_IDLE: begin
        if (i_if_req || i_d_req) begin
          own_d_d = grant_d;
          addr_d  = grant_d ? i_d_addr : i_if_addr;
          wen_d   = grant_d && i_d_wen;
          if (grant_d) wdata_d = i_d_wdata;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (!own_d_q)    if_rdata_d = i_mem_rdata;
          else if (!wen_q) d_rdata_d  = i_mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d_d = own_d_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_mem_en    = (state_q == S_CMD);
  assign o_mem_wen   = (state_q == S_CMD) && wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_if_ack    = (state_q == S_RESP) && !own_d_q;
  assign o_d_ack     = (state_q == S_RESP) && own_d_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Bench for z16_mem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances plus
// a randomized run against a transaction-level timing and memory model.
module tb_z16_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_wen;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, m_en, m_wen, busy;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  logic        t3_if_req, t3_d_req, t3_d_wen;
  logic [15:0] t3_if_addr, t3_d_addr, t3_d_wdata;
  logic        t3_if_ack, t3_d_ack, t3_en, t3_wen, t3_busy;
  logic [15:0] t3_if_rdata, t3_d_rdata, t3_addr, t3_wdata, t3_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata),
    .o_mem_en(m_en), .o_mem_wen(m_wen), .o_mem_addr(m_addr), .o_mem_wdata(m_wdata),
    .i_mem_rdata(m_rdata), .o_busy(busy)
  );

  z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(t3_if_req), .i_if_addr(t3_if_addr), .o_if_ack(t3_if_ack), .o_if_rdata(t3_if_rdata),
    .i_d_req(t3_d_req), .i_d_wen(t3_d_wen), .i_d_addr(t3_d_addr), .i_d_wdata(t3_d_wdata),
    .o_d_ack(t3_d_ack), .o_d_rdata(t3_d_rdata),
    .o_mem_en(t3_en), .o_mem_wen(t3_wen), .o_mem_addr(t3_addr), .o_mem_wdata(t3_wdata),
    .i_mem_rdata(t3_rdata), .o_busy(t3_busy)
  );

  function automatic logic [15:0] minit(int i);
    if (i == 1) return 16'h1234;
    if (i == 2) return 16'h5A5A;
    return (16'(i) * 16'h0111) ^ 16'hA000;
  endfunction

  function automatic logic [15:0] minit3(int i);
    return (16'(i) * 16'h0101) ^ 16'hC3C3;
  endfunction

  // Word-indexed memory; read data is valid only in the cycle after the command.
  logic [15:0] mem1 [256];
  logic        mem1_init = 1'b0;
  always @(posedge clk) begin
    if (!mem1_init) begin
      for (int i = 0; i < 256; i++) mem1[i] <= minit(i);
      mem1_init <= 1'b1;
    end else if (m_en && m_wen) begin
      mem1[m_addr[8:1]] <= m_wdata;
    end
    m_rdata <= (m_en && !m_wen) ? mem1[m_addr[8:1]] : 16'hDEAD;
  end

  logic [15:0] p3_0, p3_1;
  always @(posedge clk) begin
    p3_0     <= (t3_en && !t3_wen) ? minit3(int'(t3_addr[8:1])) : 16'hDEAD;
    p3_1     <= p3_0;
    t3_rdata <= p3_1;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt();
    nxt();
    tests++;
    if ({if_ack, d_ack, m_en, m_wen, busy, m_addr, m_wdata, if_rdata, d_rdata} !== 69'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0",
               {if_ack, d_ack, m_en, m_wen, busy, m_addr, m_wdata, if_rdata, d_rdata});
    end
    tests++;
    if ({t3_if_ack, t3_d_ack, t3_en, t3_busy, t3_if_rdata} !== 20'd0) begin
      fails++;
      $display("FAIL reset_outputs_lat3: got %h want 0", {t3_if_ack, t3_d_ack, t3_en, t3_busy, t3_if_rdata});
    end
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 16'h0002;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (m_en !== (c == 1)) begin fails++; $display("FAIL fetch_en c%0d: got %b want %b", c, m_en, c == 1); end
      tests++;
      if (busy !== (c >= 1)) begin fails++; $display("FAIL fetch_busy c%0d: got %b want %b", c, busy, c >= 1); end
      tests++;
      if (if_ack !== (c == 3)) begin fails++; $display("FAIL fetch_ack c%0d: got %b want %b", c, if_ack, c == 3); end
      tests++;
      if (d_ack !== 1'b0) begin fails++; $display("FAIL fetch_dack c%0d: got %b want 0", c, d_ack); end
      if (c == 1) begin
        tests++;
        if (m_addr !== 16'h0002) begin fails++; $display("FAIL fetch_addr: got %h want 0002", m_addr); end
      end
      if (c == 3) begin
        tests++;
        if (if_rdata !== 16'h1234) begin fails++; $display("FAIL fetch_rdata: got %h want 1234", if_rdata); end
        if_req = 1'b0;
      end
      nxt();
    end
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (m_wen !== (c == 1)) begin fails++; $display("FAIL store_wen c%0d: got %b want %b", c, m_wen, c == 1); end
      tests++;
      if (d_ack !== (c == 3)) begin fails++; $display("FAIL store_ack c%0d: got %b want %b", c, d_ack, c == 3); end
      if (c == 1) begin
        tests++;
        if (m_wdata !== 16'hBEEF) begin fails++; $display("FAIL store_wdata: got %h want beef", m_wdata); end
      end
      if (c == 3) begin
        tests++;
        if (d_rdata !== 16'h0000) begin fails++; $display("FAIL store_rdata_held: got %h want 0000", d_rdata); end
        d_req = 1'b0;
      end
      nxt();
    end
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0100; d_wdata = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (m_wen !== 1'b0) begin fails++; $display("FAIL load_wen c%0d: got %b want 0", c, m_wen); end
      tests++;
      if (d_ack !== (c == 3)) begin fails++; $display("FAIL load_ack c%0d: got %b want %b", c, d_ack, c == 3); end
      if (c == 3) begin
        tests++;
        if (d_rdata !== 16'hBEEF) begin fails++; $display("FAIL load_rdata: got %h want beef", d_rdata); end
        d_req = 1'b0;
      end
      nxt();
    end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0002;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      tests++;
      if (m_en !== (c == 1 || c == 5)) begin fails++; $display("FAIL tie_en c%0d: got %b", c, m_en); end
      tests++;
      if (if_ack !== (c == 3)) begin fails++; $display("FAIL tie_ifack c%0d: got %b want %b", c, if_ack, c == 3); end
      tests++;
      if (d_ack !== (c == 7)) begin fails++; $display("FAIL tie_dack c%0d: got %b want %b", c, d_ack, c == 7); end
      if (c == 1 || c == 5) begin
        tests++;
        if (m_addr !== ((c == 1) ? 16'h0002 : 16'h0100)) begin
          fails++; $display("FAIL tie_addr c%0d: got %h want %h", c, m_addr, (c == 1) ? 16'h0002 : 16'h0100);
        end
      end
      if (c == 3) begin
        tests++;
        if (if_rdata !== 16'h1234) begin fails++; $display("FAIL tie_ifrdata: got %h want 1234", if_rdata); end
        if_req = 1'b0;
      end
      if (c == 7) begin
        tests++;
        if (d_rdata !== 16'hBEEF) begin fails++; $display("FAIL tie_drdata: got %h want beef", d_rdata); end
        d_req = 1'b0;
      end
      nxt();
    end
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 16'h0002;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0100;
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (if_ack !== (c == 3 || c == 11)) begin fails++; $display("FAIL b2b_ifack c%0d: got %b", c, if_ack); end
      tests++;
      if (d_ack !== (c == 7 || c == 15)) begin fails++; $display("FAIL b2b_dack c%0d: got %b", c, d_ack); end
      if (c % 4 == 1) begin
        tests++;
        if (m_addr !== (((c / 4) % 2 == 0) ? 16'h0002 : 16'h0100)) begin
          fails++; $display("FAIL b2b_order c%0d: got %h", c, m_addr);
        end
      end
      if (c == 15) begin if_req = 1'b0; d_req = 1'b0; end
      nxt();
    end
  endtask

  task automatic test_reset_wait();
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0102;
    for (int c = 0; c < 7; c++) begin
      tests++;
      if (if_ack !== (c == 6)) begin fails++; $display("FAIL rstw_ifack c%0d: got %b want %b", c, if_ack, c == 6); end
      tests++;
      if (d_ack !== 1'b0) begin fails++; $display("FAIL rstw_dack c%0d: got %b want 0", c, d_ack); end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        tests++;
        if ({m_en, m_wen, busy, m_addr, m_wdata, if_rdata, d_rdata} !== 67'd0) begin
          fails++; $display("FAIL rstw_cleared: got %h want 0", {m_en, m_wen, busy, m_addr, m_wdata, if_rdata, d_rdata});
        end
      end
      if (c == 4) begin
        tests++;
        if (m_en !== 1'b1 || m_addr !== 16'h0004) begin
          fails++; $display("FAIL rstw_fetch_wins: got en=%b addr=%h want en=1 addr=0004", m_en, m_addr);
        end
      end
      if (c == 6) begin
        tests++;
        if (if_rdata !== 16'h5A5A) begin fails++; $display("FAIL rstw_rdata: got %h want 5a5a", if_rdata); end
        if_req = 1'b0; d_req = 1'b0;
      end
      nxt();
    end
  endtask

  task automatic test_lat3();
    t3_if_req = 1'b1; t3_if_addr = 16'h0006;
    for (int c = 0; c < 7; c++) begin
      tests++;
      if (t3_en !== (c == 1)) begin fails++; $display("FAIL lat3_en c%0d: got %b want %b", c, t3_en, c == 1); end
      tests++;
      if (t3_busy !== (c >= 1 && c <= 5)) begin fails++; $display("FAIL lat3_busy c%0d: got %b", c, t3_busy); end
      tests++;
      if (t3_if_ack !== (c == 5)) begin fails++; $display("FAIL lat3_ack c%0d: got %b want %b", c, t3_if_ack, c == 5); end
      if (c == 4) begin
        tests++;
        if (t3_if_rdata !== 16'h0000) begin fails++; $display("FAIL lat3_early: got %h want 0000", t3_if_rdata); end
      end
      if (c == 5) begin
        tests++;
        if (t3_if_rdata !== minit3(3)) begin fails++; $display("FAIL lat3_rdata: got %h want %h", t3_if_rdata, minit3(3)); end
        t3_if_req = 1'b0;
      end
      nxt();
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [256];
    int          rem;
    bit          own, last, t_wen;
    logic [15:0] t_addr, t_wdata, t_rd, exp_if, exp_d;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem1[i];
    rem = 0; own = 1'b0; last = 1'b1; t_wen = 1'b0;
    t_addr = '0; t_wdata = '0; t_rd = '0; exp_if = '0; exp_d = '0;
    for (int k = 0; k < 400; k++) begin
      tests++;
      if (m_en !== (rem == 3) || busy !== (rem != 0)) begin
        fails++; $display("FAIL rnd_en_busy k%0d: got en=%b busy=%b want rem=%0d", k, m_en, busy, rem);
      end
      tests++;
      if (if_ack !== (rem == 1 && !own) || d_ack !== (rem == 1 && own)) begin
        fails++; $display("FAIL rnd_ack k%0d: got if=%b d=%b want rem=%0d own_d=%b", k, if_ack, d_ack, rem, own);
      end
      if (rem == 3) begin
        tests++;
        if (m_addr !== t_addr || m_wen !== t_wen || (t_wen && m_wdata !== t_wdata)) begin
          fails++; $display("FAIL rnd_cmd k%0d: got %h/%b/%h want %h/%b/%h", k, m_addr, m_wen, m_wdata, t_addr, t_wen, t_wdata);
        end
      end
      tests++;
      if (if_rdata !== ((rem == 1 && !own) ? t_rd : exp_if)) begin
        fails++; $display("FAIL rnd_ifrdata k%0d: got %h want %h", k, if_rdata, (rem == 1 && !own) ? t_rd : exp_if);
      end
      tests++;
      if (d_rdata !== ((rem == 1 && own && !t_wen) ? t_rd : exp_d)) begin
        fails++; $display("FAIL rnd_drdata k%0d: got %h want %h", k, d_rdata, (rem == 1 && own && !t_wen) ? t_rd : exp_d);
      end
      if (rem == 1) begin
        if (!own) begin exp_if = t_rd; if_req = 1'b0; end
        else begin if (!t_wen) exp_d = t_rd; d_req = 1'b0; end
      end
      if (!if_req && $urandom_range(1, 0) == 1) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(255, 0)) << 1;
      end
      if (!d_req && $urandom_range(1, 0) == 1) begin
        d_req = 1'b1; d_wen = 1'($urandom_range(1, 0));
        d_addr = 16'($urandom_range(255, 0)) << 1; d_wdata = 16'($urandom);
      end
      if (rem == 0 && (if_req || d_req)) begin
        own     = d_req && (!if_req || !last);
        t_addr  = own ? d_addr : if_addr;
        t_wen   = own && d_wen;
        t_wdata = d_wdata;
        if (t_wen) ref_mem[t_addr[8:1]] = t_wdata;
        t_rd    = ref_mem[t_addr[8:1]];
        rem     = 3;
      end else if (rem > 0) begin
        if (rem == 1) last = own;
        rem--;
      end
      nxt();
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
    t3_if_req = 1'b0; t3_if_addr = '0; t3_d_req = 1'b0; t3_d_wen = 1'b0; t3_d_addr = '0; t3_d_wdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_back_to_back();
    test_reset_wait();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/z16_mem_arbiter.md
# z16_mem_arbiter

Two-port memory arbiter and access sequencer for the Z16 CPU. It shares one single-port synchronous memory between the instruction-fetch requester and the data (load/store) requester. It runs a small FSM that issues exactly one memory command per granted transaction, waits a fixed memory latency, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU core (PC/fetch path and ALU-address data path) and the unified program/data memory.

## Interface

Parameters:
- ADDR_W, 16, address width (byte address, passed through unchanged)
- DATA_W, 16, data width
- MEM_LAT, 1, cycles from memory command cycle to read data valid; legal range 1..4

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous reset, active-high
- i_if_req  input  1  fetch request; held high until o_if_ack
- i_if_addr  input  ADDR_W  fetch address; stable while i_if_req high
- o_if_ack  output  1  one-cycle pulse: fetch complete, o_if_rdata valid
- o_if_rdata  output  DATA_W  fetched instruction, registered
- i_d_req  input  1  data request; held high until o_d_ack
- i_d_wen  input  1  1 = store, 0 = load; stable while i_d_req high
- i_d_addr  input  ADDR_W  data address
- i_d_wdata  input  DATA_W  store data
- o_d_ack  output  1  one-cycle pulse: data access complete
- o_d_rdata  output  DATA_W  load data, registered
- o_mem_en  output  1  memory command strobe, high only in CMD
- o_mem_wen  output  1  memory write enable, high only in CMD of a store
- o_mem_addr  output  ADDR_W  registered memory address
- o_mem_wdata  output  DATA_W  registered memory write data
- i_mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after CMD
- o_busy  output  1  high in any state other than IDLE

## Operation

- States: IDLE, CMD, WAIT, RESP.
- IDLE: if no request, stay. If one request is present, grant it. If both are present, grant the requester not granted last (round-robin via last_grant register). On grant, register addr/wen/wdata into o_mem_*, record owner, then go to CMD.
- CMD: o_mem_en = 1; o_mem_wen = owner is data AND store. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement counter each cycle. On the cycle the counter equals 1, capture i_mem_rdata into the owner's rdata register (loads and fetches only), then go to RESP.
- RESP: owner's ack = 1 for this cycle only. Update last_grant to the owner. Go to IDLE.
- Requests are never re-granted in RESP, so a requester that is still holding req during its ack is not serviced twice.
- Store: o_d_rdata holds its previous value; o_d_ack still pulses in RESP.
- A request dropped before its ack (protocol violation) does not abort the transaction: it completes and the ack pulses.
- Addresses and data are not modified, aligned, or checked.
- Reset: state = IDLE; last_grant = DATA, so the fetch requester wins the first tie. All outputs are 0: acks, o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata, both rdata registers, o_busy. Reset in any state abandons the transaction and no ack is produced.

## Timing

- Cycle 0 is the IDLE cycle in which the request is sampled.
- o_mem_en/o_mem_addr are valid in cycle 1 (CMD).
- Read data is captured at the end of cycle 1+MEM_LAT.
- Ack and rdata are valid in cycle 2+MEM_LAT (RESP).
- FSM is back in IDLE in cycle 3+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles.
- Latency from request to ack for an uncontended request: MEM_LAT+2 cycles.
- o_busy is high in cycles 1 through 2+MEM_LAT.
- A request arriving during a transaction waits and is sampled in the next IDLE cycle.
- Memory model contract: it samples on the edge ending CMD. For MEM_LAT = 1 it drives i_mem_rdata valid in the following cycle.

## Test plan

- Reset, then fetch at 0x0002 with memory word 0x1234, MEM_LAT=1 -> o_mem_en=1 and o_mem_addr=0x0002 in cycle 1 only; o_if_ack pulse in cycle 3 with o_if_rdata=0x1234; o_d_ack stays 0.
- Store 0xBEEF to 0x0100 -> o_mem_wen=1 in cycle 1 only, o_mem_wdata=0xBEEF; o_d_ack in cycle 3; o_d_rdata unchanged; later load of 0x0100 returns 0xBEEF.
- Fetch and data requests both asserted in cycle 0 after reset -> fetch is granted first with o_if_ack in cycle 3; data o_mem_en in cycle 5; o_d_ack in cycle 7.
- Both requesters held continuously for 4 transactions -> grant order is IF, D, IF, D; each ack occurs exactly once, 4 cycles apart; no double service.
- i_rst asserted for one cycle during WAIT -> next cycle all outputs are 0, state is IDLE, no ack appears; with both requests still held after release, fetch wins.
- MEM_LAT=3 fetch -> WAIT lasts cycles 2-4; rdata is captured at the end of cycle 4; o_if_ack in cycle 5; o_busy high in cycles 1-5.
